gpio_bank: RTL and testbench
============================

Name: gpio_bank

Overview:
- Parametrised memory-mapped GPIO bank on the CPU data bus; next generation of the fixed 32-bit in/out register pair.
- Adds per-pin direction control, atomic set/clear/toggle of outputs, input synchronisation, and rise/fall edge capture with write-1-to-clear pending bits and a single interrupt line.
- Sits behind the data-memory address decoder. Bus protocol is unchanged: single-cycle write strobe, registered read data.

Parameters:
- WIDTH, 32, number of pins (1..32); register bits [31:WIDTH] read 0 and ignore writes.
- BASE, 32'h0000_0000, word-aligned base address of the register window.
- SYNC_STAGES, 2, flip-flop stages on each io_in bit (>=2).
- DEBOUNCE_CYCLES, 16, stability window in clocks; used only with GPIO_DEBOUNCE_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- we  input  1  write strobe for the current addr.
- addr  input  32  byte address, word-aligned.
- wd  input  32  write data.
- rd  output  32  registered read data.
- io_in  input  WIDTH  asynchronous pin inputs.
- io_out  output  WIDTH  output data register OUT.
- io_oe  output  WIDTH  output enable (DIR register); 1 = drive pin.
- irq  output  1  level interrupt, OR of PEND bits.

Behaviour:
- Register map, offsets from BASE:
  - 0x00 IN, RO: synchronised (or debounced) pins.
  - 0x04 OUT, RW.
  - 0x08 OUT_SET, WO: OUT |= wd.
  - 0x0C OUT_CLR, WO: OUT &= ~wd.
  - 0x10 OUT_TGL, WO: OUT ^= wd.
  - 0x14 DIR, RW.
  - 0x18 IE_RISE, RW.
  - 0x1C IE_FALL, RW.
  - 0x20 PEND, RW1C.
- Read behaviour:
  - WO registers read 0. Unmapped offsets and addresses outside the window read 0; writes to them are ignored.
  - No read strobe: every cycle, rd <= value selected by addr, so rd is valid one cycle after addr.
- Reset: OUT, DIR, IE_RISE, IE_FALL, PEND, all sync/prev flops and rd = 0. Consequently io_out = 0, io_oe = 0, irq = 0.
- Signal path:
  - Input path: io_in passes through a SYNC_STAGES chain; its output is s.
  - prev <= s every cycle.
  - rise = s & ~prev & IE_RISE; fall = ~s & prev & IE_FALL.
  - PEND <= (PEND & ~clr) | rise | fall, where clr = wd when writing PEND, else 0. On the same bit, a new edge (set) wins over clear.
  - irq = |PEND, driven from flops only; no combinational path from any input.
- Latency from an io_in change, measured in rising edges:
  - s reflects the change after SYNC_STAGES edges.
  - PEND and irq update on the next edge.
  - An IN read issued after s has changed returns the new value one edge later.
- Boundary behaviour:
  - Pins with DIR=1 still sample into IN, so outputs read back with sync delay.
  - io_out presents OUT regardless of DIR.
  - Enabling IE does not retro-flag an edge that occurred while disabled.
  - A pin held high through reset release causes an internal 0->1 on s that is masked because IE=0 at reset.
- Reset asserted mid-operation clears all state immediately (asynchronous), including pending interrupts.

Optional Feature:
- Macro: GPIO_DEBOUNCE_EN.
- Defined:
  - Per-pin counter of width clog2(DEBOUNCE_CYCLES+1) placed after the sync chain.
  - The debounced value d takes the new s only after s has differed from d for DEBOUNCE_CYCLES consecutive cycles; any return to d resets the counter.
  - IN and edge detection use d in place of s.
  - A glitch shorter than DEBOUNCE_CYCLES produces no IN change and no PEND.
  - Counters reset to 0 and d resets to 0.
- Undefined: no counters; DEBOUNCE_CYCLES is ignored; d = s.

Test Plan:
- Reset, then read each offset 0x00..0x20 and 0x24 -> all rd = 0; io_out = 0, io_oe = 0, irq = 0.
- Sequence:
  1. Write OUT = 0x0000_00F0 -> io_out = 0xF0.
  2. Write OUT_SET 0x0F -> io_out = 0xFF.
  3. Write OUT_CLR 0x3C -> io_out = 0xC3.
  4. Write OUT_TGL 0xFF -> io_out = 0x3C.
  5. Read OUT -> 0x3C.
- Write DIR = 0x0000_FFFF -> io_oe = 0xFFFF. Drive io_in = 0xA5A5_0000, wait 3 edges, read IN -> 0xA5A5_0000.
- Set IE_RISE = 0x1. Raise io_in[0] -> PEND = 0x1 and irq = 1 exactly SYNC_STAGES+1 edges later. Write PEND = 0x1 -> PEND = 0, irq = 0 next cycle. Set IE_FALL = 0x2 and drop io_in[1] -> PEND = 0x2.
- Collision: a rising edge on bit 0 lands in the same cycle as a PEND write of 0x1 -> PEND[0] stays 1. Assert rstn low mid-sequence -> all registers 0 immediately.
- With GPIO_DEBOUNCE_EN and DEBOUNCE_CYCLES = 16: a 10-cycle pulse on io_in[2] -> IN[2] stays 0 and no PEND. A 20-cycle pulse -> IN[2] = 1 after SYNC_STAGES+16 edges.

Source files
------------

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: OUT/DIR/IE registers, atomic set/clear/toggle, synchronised inputs, edge-pend irq.
// Build option: define GPIO_DEBOUNCE_EN to add a per-pin debounce filter after the sync chain.

module gpio_pin #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin,
    output logic d
);
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("gpio_pin: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) sync <= '0;
        else       sync <= {sync[SYNC_STAGES-2:0], pin};
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] cnt;
    logic          s;

    assign s = sync[SYNC_STAGES-1];

    // d only follows s after DEBOUNCE_CYCLES consecutive cycles of disagreement
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
            d   <= 1'b0;
        end else if (s == d) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            d   <= s;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign d = sync[SYNC_STAGES-1];
`endif
endmodule

module gpio_bank #(
    parameter int          WIDTH           = 32,
    parameter logic [31:0] BASE            = 32'h0000_0000,
    parameter int          SYNC_STAGES     = 2,
    parameter int          DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we,
    input  logic [31:0]      addr,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_oe,
    output logic             irq
);
    typedef enum logic [3:0] {
        R_IN, R_OUT, R_SET, R_CLR, R_TGL, R_DIR, R_IER, R_IEF, R_PEND
    } reg_e;

    logic [WIDTH-1:0] s, prev, out_r, dir_r, ie_r, ie_f, pend;
    logic [WIDTH-1:0] rise, fall, clr, wd_w;
    logic [31:0]      off, rdata;
    logic             hit;
    reg_e             idx;

    gpio_pin #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pin [WIDTH-1:0] (
        .clk  (clk),
        .rstn (rstn),
        .pin  (io_in),
        .d    (s)
    );

    // Unsigned difference makes addresses below BASE wrap high and miss the window
    assign off  = addr - BASE;
    assign hit  = (off < 32'h24) && (off[1:0] == 2'b00);
    assign idx  = reg_e'(off[5:2]);
    assign wd_w = wd[WIDTH-1:0];

    assign rise = s & ~prev & ie_r;
    assign fall = ~s & prev & ie_f;
    assign clr  = (we && hit && idx == R_PEND) ? wd_w : '0;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (idx)
                R_IN:    rdata[WIDTH-1:0] = s;
                R_OUT:   rdata[WIDTH-1:0] = out_r;
                R_DIR:   rdata[WIDTH-1:0] = dir_r;
                R_IER:   rdata[WIDTH-1:0] = ie_r;
                R_IEF:   rdata[WIDTH-1:0] = ie_f;
                R_PEND:  rdata[WIDTH-1:0] = pend;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev  <= '0;
            out_r <= '0;
            dir_r <= '0;
            ie_r  <= '0;
            ie_f  <= '0;
            pend  <= '0;
            rd    <= '0;
        end else begin
            prev <= s;
            rd   <= rdata;
            // new edges are OR'd in after the clear so a colliding edge survives
            pend <= (pend & ~clr) | rise | fall;
            if (we && hit) begin
                case (idx)
                    R_OUT:   out_r <= wd_w;
                    R_SET:   out_r <= out_r | wd_w;
                    R_CLR:   out_r <= out_r & ~wd_w;
                    R_TGL:   out_r <= out_r ^ wd_w;
                    R_DIR:   dir_r <= wd_w;
                    R_IER:   ie_r  <= wd_w;
                    R_IEF:   ie_f  <= wd_w;
                    default: ;
                endcase
            end
        end
    end

    assign io_out = out_r;
    assign io_oe  = dir_r;
    assign irq    = |pend;
endmodule

// File: tb/tb_gpio_bank.sv
// Scoreboard bench for gpio_bank (default build): directed register/pin sequences, expected values queued at issue.

module tb_gpio_bank;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int K_RD = 0, K_OUT = 1, K_OE = 2, K_IRQ = 3;

    logic        clk = 1'b0;
    logic        rstn, we;
    logic [31:0] addr, wd, rd, io_in, io_out, io_oe;
    logic        irq;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
        int          due;
    } chk_t;

    chk_t sbq[$];
    int   cyc_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    gpio_bank #(.WIDTH(32), .BASE(BASE), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(16)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .we     (we),
        .addr   (addr),
        .wd     (wd),
        .rd     (rd),
        .io_in  (io_in),
        .io_out (io_out),
        .io_oe  (io_oe),
        .irq    (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic void compare(string n, logic [31:0] act, logic [31:0] e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", n, act, e);
        end
    endfunction

    // Monitor: each queued item is due one edge after it was issued
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc_cnt) begin
            chk_t        it;
            logic [31:0] act;
            it = sbq.pop_front();
            case (it.kind)
                K_RD:    act = rd;
                K_OUT:   act = io_out;
                K_OE:    act = io_oe;
                default: act = {31'b0, irq};
            endcase
            compare(it.name, act, it.exp);
        end
    end

    task automatic expect_v(int kind, logic [31:0] e, string n);
        sbq.push_back('{kind, e, n, cyc_cnt + 1});
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wr(logic [31:0] a, logic [31:0] d);
        we = 1'b1; addr = a; wd = d;
        cyc();
        we = 1'b0;
    endtask

    task automatic rdchk(logic [31:0] a, logic [31:0] e, string n);
        addr = a;
        expect_v(K_RD, e, n);
        cyc();
    endtask

    initial begin
        rstn = 1'b0; we = 1'b0; addr = '0; wd = '0; io_in = '0;
        repeat (2) cyc();
        rstn = 1'b1;

        // reset state
        expect_v(K_OUT, 32'h0, "rst_io_out");
        expect_v(K_OE,  32'h0, "rst_io_oe");
        expect_v(K_IRQ, 32'h0, "rst_irq");
        for (int o = 0; o <= 'h24; o += 4) rdchk(BASE + o, 32'h0, $sformatf("rst_rd_%02h", o));

        // output register and atomic ops
        expect_v(K_OUT, 32'hF0, "out_wr");   wr(BASE + 'h04, 32'hF0);
        expect_v(K_OUT, 32'hFF, "out_set");  wr(BASE + 'h08, 32'h0F);
        expect_v(K_OUT, 32'hC3, "out_clr");  wr(BASE + 'h0C, 32'h3C);
        expect_v(K_OUT, 32'h3C, "out_tgl");  wr(BASE + 'h10, 32'hFF);
        rdchk(BASE + 'h04, 32'h3C, "out_rd");
        rdchk(BASE + 'h08, 32'h0, "set_reads0");
        rdchk(32'h0000_0004, 32'h0, "outside_win");
        wr(BASE + 'h24, 32'hFFFF_FFFF);
        rdchk(BASE + 'h04, 32'h3C, "unmapped_wr");

        // direction and input path
        expect_v(K_OE, 32'hFFFF, "dir_oe");  wr(BASE + 'h14, 32'h0000_FFFF);
        rdchk(BASE + 'h14, 32'hFFFF, "dir_rd");
        io_in = 32'hA5A5_0000;
        repeat (3) cyc();
        rdchk(BASE, 32'hA5A5_0000, "in_rd");

        // rising edge latency: PEND set SYNC_STAGES+1 edges after the pin change
        wr(BASE + 'h18, 32'h1);
        io_in[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            addr = BASE + 'h20;
            expect_v(K_RD,  (k >= 3) ? 32'h1 : 32'h0, $sformatf("pend_lat%0d", k));
            expect_v(K_IRQ, (k >= 2) ? 32'h1 : 32'h0, $sformatf("irq_lat%0d", k));
            cyc();
        end
        expect_v(K_IRQ, 32'h0, "irq_w1c");
        wr(BASE + 'h20, 32'h1);
        rdchk(BASE + 'h20, 32'h0, "pend_w1c");

        // falling edge; a rise on bit1 must not flag
        wr(BASE + 'h1C, 32'h2);
        io_in[1] = 1'b1;
        repeat (4) cyc();
        rdchk(BASE + 'h20, 32'h0, "no_rise_b1");
        io_in[1] = 1'b0;
        repeat (4) cyc();
        expect_v(K_IRQ, 32'h1, "irq_fall");
        rdchk(BASE + 'h20, 32'h2, "pend_fall");
        wr(BASE + 'h20, 32'h2);

        // enabling IE after an edge must not retro-flag it
        io_in[3] = 1'b1;
        repeat (4) cyc();
        wr(BASE + 'h18, 32'h9);
        repeat (2) cyc();
        rdchk(BASE + 'h20, 32'h0, "ie_no_retro");
        rdchk(BASE, 32'hA5A5_0009, "in_b3");

        // collision: rise reaches PEND on the same edge as a W1C of that bit
        io_in[0] = 1'b0;
        repeat (4) cyc();
        io_in[0] = 1'b1;
        repeat (2) cyc();
        wr(BASE + 'h20, 32'h1);
        rdchk(BASE + 'h20, 32'h1, "collision");

        // asynchronous reset mid-operation
        #2 rstn = 1'b0;
        #1;
        compare("arst_io_out", io_out, 32'h0);
        compare("arst_io_oe",  io_oe,  32'h0);
        compare("arst_irq",    {31'b0, irq}, 32'h0);
        compare("arst_rd",     rd,     32'h0);
        cyc();
        rstn = 1'b1;
        repeat (4) cyc();
        rdchk(BASE + 'h20, 32'h0, "rst_pin_high_masked");
        rdchk(BASE + 'h04, 32'h0, "rst_out");
        rdchk(BASE + 'h14, 32'h0, "rst_dir");
        rdchk(BASE, 32'hA5A5_0009, "in_after_rst");

        repeat (3) cyc();
        if (sbq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
